// File: rtl/lc4_arith_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : lc4_arith_seq_if
// Purpose  : Request/response bundle between the issuing stage and the
//            sequential LC4 arithmetic unit (valid/ready request side plus
//            the one-cycle result pulse).
// Revision : 1.0 - initial release
// ============================================================================
interface lc4_arith_seq_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [5:0]       i_imm;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;
    logic             o_div_zero;
    logic             o_bad_op;

    // Issuing stage view
    modport master (
        output i_valid, i_op, i_a, i_b, i_imm,
        input  o_ready, o_valid, o_result, o_div_zero, o_bad_op
    );

    // Arithmetic unit view
    modport slave (
        input  i_valid, i_op, i_a, i_b, i_imm,
        output o_ready, o_valid, o_result, o_div_zero, o_bad_op
    );
endinterface
`default_nettype wire

// File: rtl/lc4_arith_seq.sv
`default_nettype none
// ============================================================================
// Module   : lc4_arith_seq
// Purpose  : Multi-cycle LC4 arithmetic unit. ADD/SUB/ADDIMM5/ADDIMM6 and
//            the reserved opcode complete in one cycle; MUL uses a
//            shift-add datapath and DIV/MOD a restoring divider, one bit
//            per cycle, so no wide multiplier/divider sits in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lc4_arith_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    lc4_arith_seq_if.slave bus
);

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_MUL  = 3'd1;
    localparam logic [2:0] c_OP_SUB  = 3'd2;
    localparam logic [2:0] c_OP_DIV  = 3'd3;
    localparam logic [2:0] c_OP_MOD  = 3'd4;
    localparam logic [2:0] c_OP_IMM5 = 3'd5;
    localparam logic [2:0] c_OP_IMM6 = 3'd6;

    // The first iteration is performed on the accept edge itself, so the
    // counter is loaded with the number of iterations still to go. The op
    // completes on the edge where it steps from 1 to 0, giving a result
    // exactly WIDTH cycles after the accept cycle.
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    // Shared iterative datapath:
    //   r_acc : MUL accumulator      / DIV partial remainder
    //   r_x   : MUL multiplicand     / DIV dividend-quotient shift register
    //   r_y   : MUL multiplier       / DIV divisor (constant during the run)
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_x, w_x_nxt;
    logic [WIDTH-1:0] r_y, w_y_nxt;
    logic             r_is_mod, w_is_mod_nxt;

    logic             r_valid, w_valid_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_div_zero, w_div_zero_nxt;
    logic             r_bad_op, w_bad_op_nxt;

    logic             w_idle;
    logic             w_accept;

    // Single-cycle adder operands
    logic [WIDTH-1:0] w_add_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;

    // One iteration step, sourced from the inputs on the accept edge and
    // from the datapath registers while running.
    logic [WIDTH-1:0] w_src_acc, w_src_x, w_src_y;
    logic [WIDTH-1:0] w_mul_acc, w_mul_x, w_mul_y;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_div_rem, w_div_quo;
    logic             w_dvsr_zero;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = bus.i_valid && w_idle;

    assign w_src_acc = w_idle ? '0       : r_acc;
    assign w_src_x   = w_idle ? bus.i_a  : r_x;
    assign w_src_y   = w_idle ? bus.i_b  : r_y;

    assign w_mul_acc = w_src_acc + (w_src_y[0] ? w_src_x : '0);
    assign w_mul_x   = {w_src_x[WIDTH-2:0], 1'b0};
    assign w_mul_y   = {1'b0, w_src_y[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit, subtract the divisor
    // if it fits. When it fits the difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    assign w_rem_sh    = {w_src_acc, w_src_x[WIDTH-1]};
    assign w_fits      = (w_rem_sh >= {1'b0, w_src_y});
    assign w_diff      = w_rem_sh[WIDTH-1:0] - w_src_y;
    assign w_div_rem   = w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_div_quo   = {w_src_x[WIDTH-2:0], w_fits};
    assign w_dvsr_zero = (w_src_y == '0);

    // Operand B select for the shared add/subtract/immediate adder
    always_comb begin
        w_add_b = bus.i_b;
        w_cin   = 1'b0;
        case (bus.i_op)
            c_OP_SUB: begin
                w_add_b = ~bus.i_b;
                w_cin   = 1'b1;
            end
            c_OP_IMM5: w_add_b = {{(WIDTH-5){bus.i_imm[4]}}, bus.i_imm[4:0]};
            c_OP_IMM6: w_add_b = {{(WIDTH-6){bus.i_imm[5]}}, bus.i_imm[5:0]};
            default:   w_add_b = bus.i_b;
        endcase
    end

    assign w_sum = bus.i_a + w_add_b + {{(WIDTH-1){1'b0}}, w_cin};

    // Next-state, datapath and result selection
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_is_mod_nxt   = r_is_mod;
        w_valid_nxt    = 1'b0;
        w_result_nxt   = r_result;
        w_div_zero_nxt = r_div_zero;
        w_bad_op_nxt   = r_bad_op;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.i_op)
                        c_OP_ADD, c_OP_SUB, c_OP_IMM5, c_OP_IMM6: begin
                            w_valid_nxt    = 1'b1;
                            w_result_nxt   = w_sum;
                            w_div_zero_nxt = 1'b0;
                            w_bad_op_nxt   = 1'b0;
                        end
                        c_OP_MUL: begin
                            w_state_nxt = S_MUL_RUN;
                            w_cnt_nxt   = c_CNT_LOAD;
                            w_acc_nxt   = w_mul_acc;
                            w_x_nxt     = w_mul_x;
                            w_y_nxt     = w_mul_y;
                        end
                        c_OP_DIV, c_OP_MOD: begin
                            w_state_nxt  = S_DIV_RUN;
                            w_cnt_nxt    = c_CNT_LOAD;
                            w_acc_nxt    = w_div_rem;
                            w_x_nxt      = w_div_quo;
                            w_y_nxt      = w_src_y;
                            w_is_mod_nxt = (bus.i_op == c_OP_MOD);
                        end
                        default: begin
                            w_valid_nxt    = 1'b1;
                            w_result_nxt   = '0;
                            w_div_zero_nxt = 1'b0;
                            w_bad_op_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL_RUN: begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                w_acc_nxt = w_mul_acc;
                w_x_nxt   = w_mul_x;
                w_y_nxt   = w_mul_y;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt    = S_IDLE;
                    w_valid_nxt    = 1'b1;
                    w_result_nxt   = w_mul_acc;
                    w_div_zero_nxt = 1'b0;
                    w_bad_op_nxt   = 1'b0;
                end
            end
            S_DIV_RUN: begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                w_acc_nxt = w_div_rem;
                w_x_nxt   = w_div_quo;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt    = S_IDLE;
                    w_valid_nxt    = 1'b1;
                    w_div_zero_nxt = w_dvsr_zero;
                    w_bad_op_nxt   = 1'b0;
                    if (w_dvsr_zero) begin
                        w_result_nxt = '0;
                    end else if (r_is_mod) begin
                        w_result_nxt = w_div_rem;
                    end else begin
                        w_result_nxt = w_div_quo;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Iterative datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_is_mod <= 1'b0;
        end else begin
            r_acc    <= w_acc_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_is_mod <= w_is_mod_nxt;
        end
    end

    // Result registers; result and flags hold until the next completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
            r_bad_op   <= 1'b0;
        end else begin
            r_valid    <= w_valid_nxt;
            r_result   <= w_result_nxt;
            r_div_zero <= w_div_zero_nxt;
            r_bad_op   <= w_bad_op_nxt;
        end
    end

    assign bus.o_ready    = w_idle;
    assign bus.o_valid    = r_valid;
    assign bus.o_result   = r_result;
    assign bus.o_div_zero = r_div_zero;
    assign bus.o_bad_op   = r_bad_op;

endmodule
`default_nettype wire

// File: tb/tb_lc4_arith_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc4_arith_seq
// Purpose  : Self-checking bench for lc4_arith_seq (WIDTH=16 main instance,
//            WIDTH=8 secondary instance) against a cycle-count reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc4_arith_seq;

    localparam int W  = 16;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc4_arith_seq_if #(.WIDTH(W))  bus ();
    lc4_arith_seq_if #(.WIDTH(W8)) bus8 ();

    lc4_arith_seq #(.WIDTH(W))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    lc4_arith_seq #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions
    function automatic logic [W-1:0] ref_result(input int op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [5:0] imm);
        longint ua;
        longint ub;
        longint r;
        longint s5;
        longint s6;
        ua = longint'(a);
        ub = longint'(b);
        s5 = longint'(imm[4:0]);
        if (imm[4]) s5 = s5 - 32;
        s6 = longint'(imm);
        if (imm[5]) s6 = s6 - 64;
        case (op)
            0:       r = ua + ub;
            1:       r = ua * ub;
            2:       r = ua - ub;
            3:       r = (ub == 0) ? 0 : ua / ub;
            4:       r = (ub == 0) ? 0 : ua % ub;
            5:       r = ua + s5;
            6:       r = ua + s6;
            default: r = 0;
        endcase
        return W'(r);
    endfunction

    // Reference model: tracks which cycle each accepted op must complete in
    int         cyc = 0;
    logic       m_ready = 1'b1;
    logic       m_acc;
    logic       e_valid = 1'b0;
    logic [W-1:0] e_res = '0;
    logic       e_dz = 1'b0;
    logic       e_bad = 1'b0;
    int         p_due = -1;
    logic [W-1:0] p_res = '0;
    logic       p_dz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc     = 0;
            m_ready = 1'b1;
            e_valid = 1'b0;
            e_res   = '0;
            e_dz    = 1'b0;
            e_bad   = 1'b0;
            p_due   = -1;
        end else begin
            m_acc   = bus.i_valid && m_ready;
            cyc     = cyc + 1;
            e_valid = 1'b0;
            if (p_due == cyc) begin
                e_valid = 1'b1;
                e_res   = p_res;
                e_dz    = p_dz;
                e_bad   = 1'b0;
                p_due   = -1;
            end
            if (m_acc) begin
                if (bus.i_op == 3'd1 || bus.i_op == 3'd3 || bus.i_op == 3'd4) begin
                    p_due = cyc + W - 1;
                    p_res = ref_result(int'(bus.i_op), bus.i_a, bus.i_b, bus.i_imm);
                    p_dz  = (bus.i_op != 3'd1) && (bus.i_b == '0);
                end else begin
                    e_valid = 1'b1;
                    e_res   = ref_result(int'(bus.i_op), bus.i_a, bus.i_b, bus.i_imm);
                    e_dz    = 1'b0;
                    e_bad   = (bus.i_op == 3'd7);
                end
            end
            m_ready = (p_due == -1);
        end
    end

    // Cycle-by-cycle comparison of the 16-bit instance against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", 64'(bus.o_ready), 64'(m_ready));
            chk("valid", 64'(bus.o_valid), 64'(e_valid));
            chk("result", 64'(bus.o_result), 64'(e_res));
            if (e_valid) begin
                chk("div_zero", 64'(bus.o_div_zero), 64'(e_dz));
                chk("bad_op", 64'(bus.o_bad_op), 64'(e_bad));
            end
        end
    end

    // Present a request at a falling edge and hold it until accepted;
    // returns at the falling edge just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [5:0] imm);
        int t;
        t = 0;
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_imm   = imm;
        while (!bus.o_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 64'(t), 64'(0));
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // Count cycles from the accept cycle to o_valid; optionally offers an
    // ADD while the unit is busy to show it is ignored.
    task automatic wait_valid(output int n, input bit poke);
        n = 1;
        while (!bus.o_valid && n < 100) begin
            if (poke) begin
                bus.i_valid = (n < 6);
                bus.i_op    = 3'd0;
                bus.i_a     = 16'h0007;
                bus.i_b     = 16'h0009;
            end
            @(negedge clk);
            n++;
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic run_iter(input string name, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_res, input bit exp_dz);
        int n;
        issue(op, a, b, 6'd0);
        wait_valid(n, 1'b0);
        chk({name, "_latency"}, 64'(n), 64'(W));
        chk({name, "_result"}, 64'(bus.o_result), 64'(exp_res));
        chk({name, "_div_zero"}, 64'(bus.o_div_zero), 64'(exp_dz));
    endtask

    task automatic run8(input string name, input logic [2:0] op, input logic [W8-1:0] a,
                        input logic [W8-1:0] b, input logic [W8-1:0] exp_res);
        int n;
        chk({name, "_ready_before"}, 64'(bus8.o_ready), 64'(1));
        bus8.i_valid = 1'b1;
        bus8.i_op    = op;
        bus8.i_a     = a;
        bus8.i_b     = b;
        @(negedge clk);
        bus8.i_valid = 1'b0;
        chk({name, "_ready_busy"}, 64'(bus8.o_ready), 64'(0));
        n = 1;
        while (!bus8.o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(W8));
        chk({name, "_result"}, 64'(bus8.o_result), 64'(exp_res));
    endtask

    initial begin
        int n;
        int hits;
        logic [2:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        logic [5:0]   r_imm;

        bus.i_valid  = 1'b0;
        bus.i_op     = '0;
        bus.i_a      = '0;
        bus.i_b      = '0;
        bus.i_imm    = '0;
        bus8.i_valid = 1'b0;
        bus8.i_op    = '0;
        bus8.i_a     = '0;
        bus8.i_b     = '0;
        bus8.i_imm   = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 64'(bus.o_ready), 64'(1));
        chk("rst_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_result", 64'(bus.o_result), 64'(0));
        chk("rst_flags", 64'({bus.o_div_zero, bus.o_bad_op}), 64'(0));

        // Back-to-back single-cycle ops
        issue(3'd0, 16'h7FFF, 16'h0001, 6'h00);
        chk("add_res", 64'(bus.o_result), 64'h8000);
        chk("add_valid", 64'(bus.o_valid), 64'(1));
        issue(3'd2, 16'h0000, 16'h0001, 6'h00);
        chk("sub_res", 64'(bus.o_result), 64'hFFFF);
        issue(3'd5, 16'h0010, 16'h0000, 6'h1F);
        chk("imm5_res", 64'(bus.o_result), 64'h000F);
        issue(3'd6, 16'h0010, 16'h0000, 6'h20);
        chk("imm6_res", 64'(bus.o_result), 64'hFFF0);
        chk("stream_ready", 64'(bus.o_ready), 64'(1));

        // Reset in the middle of a multiply
        issue(3'd1, 16'd3, 16'd5, 6'h00);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.o_valid), 64'(0));
        chk("midrst_result", 64'(bus.o_result), 64'(0));
        chk("midrst_flags", 64'({bus.o_div_zero, bus.o_bad_op}), 64'(0));
        chk("midrst_ready", 64'(bus.o_ready), 64'(1));
        #10 rst_n = 1'b1;
        @(negedge clk);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_valid) hits++;
            @(negedge clk);
        end
        chk("midrst_no_valid", 64'(hits), 64'(0));

        // Multiply
        run_iter("mul1", 3'd1, 16'h0123, 16'h0045, 16'h4E6F, 1'b0);
        run_iter("mul2", 3'd1, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);

        // Divide / modulo
        run_iter("div1", 3'd3, 16'd1000, 16'd7, 16'd142, 1'b0);
        run_iter("mod1", 3'd4, 16'd1000, 16'd7, 16'd6, 1'b0);
        run_iter("div2", 3'd3, 16'd5, 16'd9, 16'd0, 1'b0);
        run_iter("mod2", 3'd4, 16'hFFFF, 16'd1, 16'd0, 1'b0);

        // Divide by zero, then an ADD accepted in the o_valid cycle
        run_iter("divz", 3'd3, 16'h1234, 16'h0000, 16'h0000, 1'b1);
        issue(3'd0, 16'd1, 16'd1, 6'h00);
        chk("after_divz_res", 64'(bus.o_result), 64'd2);
        chk("after_divz_dz", 64'(bus.o_div_zero), 64'(0));

        // Requests while busy are ignored
        issue(3'd1, 16'h00FF, 16'h0101, 6'h00);
        wait_valid(n, 1'b1);
        chk("busy_latency", 64'(n), 64'(W));
        chk("busy_result", 64'(bus.o_result), 64'hFFFF);
        @(negedge clk);
        chk("busy_no_extra", 64'(bus.o_valid), 64'(0));

        // Reserved opcode
        issue(3'd7, 16'h1111, 16'h2222, 6'h15);
        chk("bad_res", 64'(bus.o_result), 64'(0));
        chk("bad_flag", 64'(bus.o_bad_op), 64'(1));
        @(negedge clk);
        chk("bad_pulse", 64'(bus.o_valid), 64'(0));

        // Narrow instance
        run8("w8_mul", 3'd1, 8'h13, 8'h0B, 8'hD1);
        run8("w8_div", 3'd3, 8'd200, 8'd7, 8'd28);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r_op  = 3'($urandom_range(0, 7));
            r_a   = W'($urandom);
            r_b   = W'($urandom);
            r_imm = 6'($urandom);
            if ($urandom_range(0, 7) == 0) r_b = '0;
            if ($urandom_range(0, 7) == 0) r_a = '1;
            if ($urandom_range(0, 7) == 0) r_b = '1;
            issue(r_op, r_a, r_b, r_imm);
        end
        repeat (W + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
